// File: rtl/mp_add_sequencer.sv
// Multi-precision add sequencer: streams limbs LSB first through one add stage, chaining carry.
// Optional MP_ADD_SUB_EN adds in_sub (A-B) sampled on the starting limb of each operation.
module mp_add_sequencer #(
  parameter  int LIMB_W    = 8,
  parameter  int MAX_LIMBS = 16,
  localparam int IDX_W     = (MAX_LIMBS > 1) ? $clog2(MAX_LIMBS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LIMB_W-1:0] in_a,
  input  logic [LIMB_W-1:0] in_b,
  input  logic              in_first,
  input  logic              in_last,
`ifdef MP_ADD_SUB_EN
  input  logic              in_sub,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LIMB_W-1:0] out_sum,
  output logic              out_last,
  output logic              out_cout,
  output logic              out_ovf,
  output logic [IDX_W-1:0]  limb_idx,
  output logic              err_len,
  output logic              busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nxt;
  logic               carry_q;
  logic [IDX_W-1:0]   idx_q;
  logic               acc, start, cin, sub_cur, len_hit, last_eff;
  logic [IDX_W-1:0]   cur_idx;
  logic [LIMB_W-1:0]  b_eff;
  logic [LIMB_W:0]    sum_w;

  assign acc      = in_valid && in_ready;
  // Any limb in IDLE starts an operation; in_first in RUN restarts it.
  assign start    = (state == IDLE) || in_first;
  assign cur_idx  = start ? '0 : idx_q;
  assign len_hit  = (cur_idx == IDX_W'(MAX_LIMBS - 1));
  assign last_eff = in_last || len_hit;

`ifdef MP_ADD_SUB_EN
  logic sub_q;
  assign sub_cur = start ? in_sub : sub_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           sub_q <= 1'b0;
    else if (acc && start) sub_q <= in_sub;
  end
`else
  assign sub_cur = 1'b0;
`endif

  // Subtraction is A + ~B + 1, the +1 entering as the starting limb's carry-in.
  assign cin   = start ? sub_cur : carry_q;
  assign b_eff = sub_cur ? ~in_b : in_b;
  assign sum_w = {1'b0, in_a} + {1'b0, b_eff} + {{LIMB_W{1'b0}}, cin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (acc) state_nxt = last_eff ? IDLE : RUN;
  end

  always_comb begin
    in_ready = !out_valid || out_ready;
    busy     = (state == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q   <= 1'b0;
      idx_q     <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      limb_idx  <= '0;
      err_len   <= 1'b0;
    end else if (acc) begin
      carry_q   <= last_eff ? 1'b0 : sum_w[LIMB_W];
      idx_q     <= last_eff ? '0 : cur_idx + IDX_W'(1);
      out_valid <= 1'b1;
      out_sum   <= sum_w[LIMB_W-1:0];
      out_last  <= last_eff;
      out_cout  <= last_eff & sum_w[LIMB_W];
      out_ovf   <= last_eff & (in_a[LIMB_W-1] == b_eff[LIMB_W-1])
                            & (sum_w[LIMB_W-1] != in_a[LIMB_W-1]);
      limb_idx  <= cur_idx;
      err_len   <= len_hit & ~in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
